// File: rtl/floppy_pkg.sv
// floppy_pkg: shared state encoding, error codes and CRC constants for the sector engine
package floppy_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SPINUP, SEEK, XFER_RD, DRAIN, XFER_WR, FIN} state_t;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IDX = 2'd1;
  localparam logic [1:0] ERR_CRC = 2'd2;
  localparam logic [1:0] ERR_DRV = 2'd3;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/floppy_crc16.sv
// floppy_crc16: word-wide CRC-16-CCITT accumulator, data bits folded in MSB-first
module floppy_crc16 import floppy_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc
);
  logic [15:0] nxt;
  always_comb begin
    nxt = crc;
    for (int i = DATA_W - 1; i >= 0; i--)
      nxt = {nxt[14:0], 1'b0} ^ ((nxt[15] ^ data[i]) ? CRC_POLY : 16'h0000);
  end
  always_ff @(posedge clk) crc <= (rst || clr) ? CRC_INIT : en ? nxt : crc;
endmodule

// File: rtl/floppy_sector_engine.sv
// floppy_sector_engine: multi-drive sector read/write engine with motor hold; FLOPPY_CRC_EN adds CRC-16 sector check
module floppy_sector_engine import floppy_pkg::*; #(
  parameter int DATA_W       = 16,
  parameter int SECTOR_WORDS = 128,
  parameter int NUM_DRIVES   = 2,
  parameter int SPINUP_CYC   = 1000,
  parameter int MOTOR_HOLD   = 5000,
  parameter int IDX_TIMEOUT  = 5,
  parameter int DRV_W        = NUM_DRIVES > 1 ? $clog2(NUM_DRIVES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DRV_W-1:0]      cmd_drive,
  input  logic [7:0]            cmd_sector,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [NUM_DRIVES-1:0] motor_on,
  output logic [NUM_DRIVES-1:0] drive_sel,
  output logic                  read_gate,
  output logic                  write_gate,
  input  logic                  index_pulse,
  input  logic                  disk_sector_start,
  input  logic [7:0]            disk_sector_id,
  input  logic [DATA_W-1:0]     disk_rd_data,
  input  logic                  disk_rd_valid,
  output logic [DATA_W-1:0]     disk_wr_data,
  output logic                  disk_wr_valid,
  input  logic                  disk_wr_ready
);
  localparam int AW = $clog2(SECTOR_WORDS);
  localparam int SW = $clog2(SPINUP_CYC + 1);
  localparam int HW = $clog2(MOTOR_HOLD + 1);
  localparam int IW = $clog2(IDX_TIMEOUT + 1);
  state_t state, nxt;
  logic wr_q, warm, idx_q;
  logic [7:0] sec_q;
  logic [AW-1:0] ptr;
  logic [SW-1:0] spin_cnt;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idx_cnt;
  logic [DATA_W-1:0] mem [SECTOR_WORDS];
  logic [DATA_W-1:0] buf_q, tail_word;
  logic accept, bad_drv, last, match, idx_rise, seek_to, crc_err, crc_bad, tail;
  logic ld_step, rd_step, wr_step, dr_step, rd_end, wr_end;
  assign accept   = cmd_valid && state == IDLE;
  assign bad_drv  = int'(cmd_drive) >= NUM_DRIVES;
  assign last     = ptr == AW'(SECTOR_WORDS - 1);
  assign match    = disk_sector_start && disk_sector_id == sec_q;
  assign idx_rise = index_pulse && !idx_q;
  assign seek_to  = state == SEEK && !match && idx_rise && idx_cnt == IW'(IDX_TIMEOUT - 1);
  assign ld_step  = state == LOAD && wr_valid;
  assign rd_step  = state == XFER_RD && disk_rd_valid;
  assign wr_step  = state == XFER_WR && disk_wr_ready;
  assign dr_step  = state == DRAIN && rd_ready;
  assign crc_err  = rd_end && crc_bad;
`ifdef FLOPPY_CRC_EN
  logic crc_ph;
  logic [15:0] crc;
  floppy_crc16 #(.DATA_W(DATA_W)) u_crc (
    .clk(clk), .rst(rst), .clr(accept), .en((rd_step || wr_step) && !crc_ph),
    .data(state == XFER_RD ? disk_rd_data : buf_q), .crc(crc)
  );
  assign tail      = crc_ph;
  assign tail_word = DATA_W'(crc);
  assign rd_end    = rd_step && crc_ph;
  assign wr_end    = wr_step && crc_ph;
  assign crc_bad   = 16'(disk_rd_data) != crc;
  always_ff @(posedge clk)
    crc_ph <= (rst || accept) ? 1'b0 : ((rd_step || wr_step) && last && !crc_ph) ? 1'b1 :
              (rd_end || wr_end) ? 1'b0 : crc_ph;
`else
  assign tail      = 1'b0;
  assign tail_word = '0;
  assign rd_end    = rd_step && last;
  assign wr_end    = wr_step && last;
  assign crc_bad   = 1'b0;
`endif
  assign buf_q         = mem[ptr];
  assign cmd_ready     = state == IDLE;
  assign wr_ready      = state == LOAD;
  assign rd_valid      = state == DRAIN;
  assign rd_data       = rd_valid ? buf_q : '0;
  assign done          = state == FIN;
  assign read_gate     = state == SEEK || state == XFER_RD;
  assign write_gate    = state == XFER_WR;
  assign disk_wr_valid = state == XFER_WR;
  assign disk_wr_data  = disk_wr_valid ? (tail ? tail_word : buf_q) : '0;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept && !bad_drv) nxt = cmd_write ? LOAD : motor_on[cmd_drive] ? SEEK : SPINUP;
      LOAD:    if (ld_step && last) nxt = warm ? SEEK : SPINUP;
      SPINUP:  if (spin_cnt == SW'(SPINUP_CYC - 1)) nxt = SEEK;
      SEEK:    nxt = match ? (wr_q ? XFER_WR : XFER_RD) : seek_to ? IDLE : SEEK;
      XFER_RD: if (rd_end) nxt = crc_bad ? IDLE : DRAIN;
      DRAIN:   if (dr_step && last) nxt = FIN;
      XFER_WR: if (wr_end) nxt = FIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if ((ld_step || rd_step) && !tail) mem[ptr] <= state == LOAD ? wr_data : disk_rd_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      {wr_q, warm, idx_q, error} <= '0;
      sec_q <= '0;
      ptr <= '0;
      spin_cnt <= '0;
      hold_cnt <= '0;
      idx_cnt <= '0;
      motor_on <= '0;
      drive_sel <= '0;
      err_code <= ERR_NONE;
    end else begin
      state <= nxt;
      idx_q <= index_pulse;
      error <= seek_to || crc_err || (accept && bad_drv);
      spin_cnt <= state == SPINUP ? spin_cnt + 1'b1 : '0;
      idx_cnt <= state != SEEK ? '0 : idx_rise ? idx_cnt + 1'b1 : idx_cnt;
      if (ld_step || ((rd_step || wr_step) && !tail) || dr_step) ptr <= ptr + 1'b1;
      if (accept) err_code <= bad_drv ? ERR_DRV : ERR_NONE;
      else if (seek_to) err_code <= ERR_IDX;
      else if (crc_err) err_code <= ERR_CRC;
      if (accept && !bad_drv) begin
        wr_q <= cmd_write;
        sec_q <= cmd_sector;
        warm <= motor_on[cmd_drive];
        ptr <= '0;
        motor_on <= NUM_DRIVES'(1) << cmd_drive;
        drive_sel <= NUM_DRIVES'(1) << cmd_drive;
      end else if (state != IDLE && nxt == IDLE) hold_cnt <= HW'(MOTOR_HOLD);
      else if (state == IDLE && !accept && motor_on != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt < HW'(2)) begin
          motor_on <= '0;
          drive_sel <= '0;
          hold_cnt <= '0;
        end
      end
    end
  end
endmodule
